// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, capture FSM states and pin-pattern payload.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NUM_GLYPHS = 16;
    localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;

    // Active-high {g,f,e,d,c,b,a}; identical to what the display controller drives.
    localparam logic [SEG_W-1:0] SEG7_GLYPH [NUM_GLYPHS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } cap_state_t;

    // Raw active-low pin snapshot as seen on the display bus.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [SEG_W-1:0]      cat;
    } pin_pat_t;

    function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] digit_index(input logic [NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of an active-high segment pattern into its hex nibble.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] segs,
    output logic [NIB_W-1:0] nibble,
    output logic             hit
);

    always_comb begin
        nibble = '0;
        hit    = 1'b0;
        for (int unsigned g = 0; g < NUM_GLYPHS; g++) begin
            if (segs == SEG7_GLYPH[g]) begin
                nibble = NIB_W'(g);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a scanned 8-digit active-low seven-segment bus and rebuilds the 32-bit value on display.
module seven_segment_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [SEG_W-1:0]      cat_in,
    input  logic [NUM_DIGITS-1:0] an_in,
    output logic [VAL_W-1:0]      val_out,
    output logic                  valid_out,
    output logic [NUM_DIGITS-1:0] digit_mask_out,
    output logic                  err_out,
    output logic [IDX_W-1:0]      err_digit_out
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    pin_pat_t              sync1_q;
    pin_pat_t              pat_q;
    pin_pat_t              prev_q;
    logic [CNT_W-1:0]      stable_cnt_q;
    cap_state_t            state_q;
    cap_state_t            state_d;
    logic [VAL_W-1:0]      shadow_q;

    logic                  changed_c;
    logic [NUM_DIGITS-1:0] act_c;
    logic [SEG_W-1:0]      segs_c;
    logic                  one_hot_c;
    logic [IDX_W-1:0]      idx_c;
    logic [NIB_W-1:0]      nibble_c;
    logic                  hit_c;
    logic                  sample_c;
    logic [NUM_DIGITS-1:0] new_mask_c;
    logic [VAL_W-1:0]      merged_c;
    logic                  frame_done_c;

    // Two-flop synchronizer plus a one-cycle history for change detection; blank after reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q <= '1;
            pat_q   <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= pin_pat_t'({an_in, cat_in});
            pat_q   <= sync1_q;
            prev_q  <= pat_q;
        end
    end

    assign changed_c = (pat_q != prev_q);
    assign act_c     = ~pat_q.an;
    assign segs_c    = ~pat_q.cat;
    assign one_hot_c = is_one_hot(act_c);
    assign idx_c     = digit_index(act_c);

    seg7_decode u_decode (
        .segs   (segs_c),
        .nibble (nibble_c),
        .hit    (hit_c)
    );

    // Counts cycles the pattern has been steady, saturating so long dwells never wrap.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stable_cnt_q <= '0;
        end else if (changed_c) begin
            stable_cnt_q <= '0;
        end else if (stable_cnt_q != CNT_W'(STABLE_CYCLES)) begin
            stable_cnt_q <= stable_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sampling fires on the edge where the counter would reach STABLE_CYCLES.
    always_comb begin
        state_d  = state_q;
        sample_c = 1'b0;
        if (!one_hot_c) begin
            state_d = IDLE;
        end else if (changed_c) begin
            state_d = SETTLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (stable_cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        sample_c = 1'b1;
                        state_d  = HELD;
                    end
                end
                HELD: begin
                    state_d = HELD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        new_mask_c                    = digit_mask_out | (NUM_DIGITS'(1) << idx_c);
        merged_c                      = shadow_q;
        merged_c[{idx_c, 2'b00} +: NIB_W] = nibble_c;
        frame_done_c                  = (new_mask_c == '1);
    end

    // Shadow/mask accumulate a frame; a completed frame is published and the mask restarts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_q       <= '0;
            digit_mask_out <= '0;
            val_out        <= '0;
            valid_out      <= 1'b0;
            err_out        <= 1'b0;
            err_digit_out  <= '0;
        end else begin
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            if (sample_c) begin
                if (hit_c) begin
                    shadow_q <= merged_c;
                    if (frame_done_c) begin
                        val_out        <= merged_c;
                        valid_out      <= 1'b1;
                        digit_mask_out <= '0;
                    end else begin
                        digit_mask_out <= new_mask_c;
                    end
                end else begin
                    err_out       <= 1'b1;
                    err_digit_out <= idx_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with STABLE_CYCLES=4 and hand-computed expectations.
module tb_seven_segment_capture;

    logic        clk_in;
    logic        rst_n_in;
    logic [6:0]  cat_in;
    logic [7:0]  an_in;
    logic [31:0] val_out;
    logic        valid_out;
    logic [7:0]  digit_mask_out;
    logic        err_out;
    logic [2:0]  err_digit_out;

    int tests_run    = 0;
    int tests_failed = 0;

    int          cyc          = 0;
    int          valid_cnt    = 0;
    int          err_cnt      = 0;
    int          mask3_rises  = 0;
    int          mask3_rise_cyc = 0;
    logic        prev_mask3   = 1'b0;
    logic [31:0] last_val     = '0;

    seven_segment_capture #(.STABLE_CYCLES(4)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .cat_in         (cat_in),
        .an_in          (an_in),
        .val_out        (val_out),
        .valid_out      (valid_out),
        .digit_mask_out (digit_mask_out),
        .err_out        (err_out),
        .err_digit_out  (err_digit_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (valid_out) begin
            valid_cnt = valid_cnt + 1;
            last_val  = val_out;
        end
        if (err_out) err_cnt = err_cnt + 1;
        if (digit_mask_out[3] && !prev_mask3) begin
            mask3_rises    = mask3_rises + 1;
            mask3_rise_cyc = cyc;
        end
        prev_mask3 = digit_mask_out[3];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Pins change 1 time unit after an edge and hold for the given number of edges.
    task automatic drive_raw(input logic [7:0] an, input logic [6:0] cat, input int cycles);
        an_in  = an;
        cat_in = cat;
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    task automatic drive_digit(input int idx, input logic [3:0] nib, input int cycles);
        drive_raw(~(8'd1 << idx), ~glyph(nib), cycles);
    endtask

    logic [31:0] word;
    int v0, e0, r0, n0;

    initial begin
        rst_n_in = 1'b0;
        an_in    = '1;
        cat_in   = '1;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_val",       val_out,        32'h0);
        check("rst_valid",     valid_out,      32'h0);
        check("rst_mask",      digit_mask_out, 32'h0);
        check("rst_err",       err_out,        32'h0);
        check("rst_err_digit", err_digit_out,  32'h0);

        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Straight scan of 0x12345678
        v0 = valid_cnt; e0 = err_cnt;
        word = 32'h1234_5678;
        for (int i = 0; i < 7; i++) drive_digit(i, word[4*i +: 4], 10);
        check("scan_partial_mask",  digit_mask_out,  32'h7F);
        check("scan_partial_valid", valid_cnt - v0,  32'd0);
        drive_digit(7, word[31:28], 10);
        drive_raw(8'hFF, 7'h7F, 10);
        check("scan_valid_count", valid_cnt - v0, 32'd1);
        check("scan_pulse_val",   last_val,       32'h1234_5678);
        check("scan_val",         val_out,        32'h1234_5678);
        check("scan_mask_clear",  digit_mask_out, 32'h0);
        check("scan_no_err",      err_cnt - e0,   32'd0);

        // Short dwell on digit 2 leaves a hole in the frame
        v0 = valid_cnt;
        word = 32'h0F1E_2D3C;
        for (int i = 0; i < 8; i++) drive_digit(i, word[4*i +: 4], (i == 2) ? 3 : 10);
        check("short_mask",  digit_mask_out, 32'hFB);
        check("short_valid", valid_cnt - v0, 32'd0);

        // Blank segments on a one-hot digit
        e0 = err_cnt;
        drive_raw(~8'b0010_0000, 7'h7F, 10);
        check("err_count", err_cnt - e0,   32'd1);
        check("err_digit", err_digit_out,  32'd5);
        check("err_mask",  digit_mask_out, 32'hFB);
        check("err_valid", valid_cnt - v0, 32'd0);

        // Two digits enabled at once: ghost pattern, ignored
        drive_raw(8'hFC, ~glyph(4'h8), 50);
        check("multi_err",   err_cnt - e0,   32'd1);
        check("multi_mask",  digit_mask_out, 32'hFB);
        check("multi_valid", valid_cnt - v0, 32'd0);

        // Filling the hole completes the frame with the older nibbles intact
        drive_digit(2, 4'hD, 10);
        check("fill_valid", valid_cnt - v0, 32'd1);
        check("fill_val",   val_out,        32'h0F1E_2D3C);
        check("fill_mask",  digit_mask_out, 32'h0);

        // Long dwell samples exactly once, E+6 after the pin change
        r0 = mask3_rises; e0 = err_cnt; v0 = valid_cnt; n0 = cyc;
        drive_digit(3, 4'h7, 1000);
        check("dwell_rises",    mask3_rises - r0, 32'd1);
        check("dwell_latency",  mask3_rise_cyc,   n0 + 7);
        check("dwell_mask",     digit_mask_out,   32'h08);
        check("dwell_no_err",   err_cnt - e0,     32'd0);
        check("dwell_no_valid", valid_cnt - v0,   32'd0);

        // Partial frame discarded by reset, then reverse-order scan
        word = 32'h5555_5555;
        for (int i = 0; i < 5; i++) drive_digit(i, word[4*i +: 4], 10);
        check("pre_rst_mask", digit_mask_out, 32'h1F);
        rst_n_in = 1'b0;
        an_in    = '1;
        cat_in   = '1;
        #1;
        check("mid_rst_val",  val_out,        32'h0);
        check("mid_rst_mask", digit_mask_out, 32'h0);
        repeat (3) @(posedge clk_in);
        #1;
        check("mid_rst_val_hold", val_out, 32'h0);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        v0 = valid_cnt;
        word = 32'hDEAD_BEEF;
        for (int i = 7; i >= 0; i--) drive_digit(i, word[4*i +: 4], 10);
        drive_raw(8'hFF, 7'h7F, 10);
        check("rev_valid_count", valid_cnt - v0, 32'd1);
        check("rev_pulse_val",   last_val,       32'hDEAD_BEEF);
        check("rev_val",         val_out,        32'hDEAD_BEEF);
        check("rev_mask",        digit_mask_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
